// File: rtl/conv_gemm_sequencer.sv
// Sequences im2col x weight GEMM passes on a systolic array from a 1-cycle-latency word memory.
// Weights load once per job; each image loads X, streams N rows, waits for the array, then stores Y.
module conv_gemm_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int M          = 9,
    parameter int N          = 9,
    parameter int K          = 2,
    parameter int BATCH_W    = 4,
    parameter int WAIT_MAX   = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      cfg_x_base,
    input  logic [ADDR_WIDTH-1:0]      cfg_w_base,
    input  logic [ADDR_WIDTH-1:0]      cfg_y_base,
    input  logic [BATCH_W-1:0]         cfg_batch,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic                       mem_wr_en,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       arr_rst_n,
    output logic [DATA_WIDTH*M-1:0]    arr_x,
    output logic [DATA_WIDTH*K-1:0]    arr_w,
    input  logic [DATA_WIDTH*M*K-1:0]  arr_y,
    input  logic                       arr_done
);
    localparam int NK      = N * K;
    localparam int NM      = N * M;
    localparam int MK      = M * K;
    localparam int C1      = (NM > NK) ? NM : NK;
    localparam int C2      = (C1 > MK) ? C1 : MK;
    localparam int CNT_MAX = (C2 > WAIT_MAX) ? C2 : WAIT_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RX      = DATA_WIDTH * M;
    localparam int RW      = DATA_WIDTH * K;
    localparam int XW      = DATA_WIDTH * NM;
    localparam int WW      = DATA_WIDTH * NK;
    localparam int YW      = DATA_WIDTH * MK;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_STREAM, S_WAIT, S_STORE, S_DONE
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]  x_base, w_base, y_base;
    logic [BATCH_W-1:0]     batch, b;
    logic                   rd_vld, rd_w;
    logic                   accept, timeout, store_last, last_img, rd_issue;
    logic [XW-1:0]          x_buf;
    logic [WW-1:0]          w_buf;
    logic [YW-1:0]          y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        timeout    = 1'b0;
        store_last = 1'b0;
        rd_issue   = 1'b0;
        last_img   = (b == batch - BATCH_W'(1));
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        arr_rst_n  = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                accept  = 1'b1;
                state_n = (cfg_batch == '0) ? S_DONE : S_LOAD_W;
            end
            S_LOAD_W: begin
                if (cnt < CNT_W'(NK)) begin
                    rd_issue = 1'b1;
                    mem_addr = w_base + ADDR_WIDTH'(cnt);
                end else begin
                    state_n  = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                if (cnt < CNT_W'(NM)) begin
                    rd_issue = 1'b1;
                    mem_addr = x_base + ADDR_WIDTH'(cnt);
                end else begin
                    state_n  = S_STREAM;
                end
            end
            S_STREAM: begin
                arr_rst_n = 1'b1;
                if (cnt == CNT_W'(N - 1)) state_n = S_WAIT;
            end
            S_WAIT: begin
                arr_rst_n = 1'b1;
                if (arr_done) begin
                    state_n = S_STORE;
                end else if (cnt == CNT_W'(WAIT_MAX - 1)) begin
                    timeout = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_STORE: begin
                mem_wr_en = 1'b1;
                mem_addr  = y_base + ADDR_WIDTH'(cnt);
                mem_wdata = y_reg[DATA_WIDTH-1:0];
                if (cnt == CNT_W'(MK - 1)) begin
                    store_last = 1'b1;
                    state_n    = last_img ? S_DONE : S_LOAD_X;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            x_base <= '0;
            w_base <= '0;
            y_base <= '0;
            batch  <= '0;
            b      <= '0;
            err    <= 1'b0;
            rd_vld <= 1'b0;
            rd_w   <= 1'b0;
            arr_x  <= '0;
            arr_w  <= '0;
        end else begin
            cnt    <= (state_n != state || state == S_IDLE) ? '0 : cnt + 1'b1;
            rd_vld <= rd_issue;
            rd_w   <= (state == S_LOAD_W);
            if (accept) begin
                x_base <= cfg_x_base;
                w_base <= cfg_w_base;
                y_base <= cfg_y_base;
                batch  <= cfg_batch;
                b      <= '0;
                err    <= 1'b0;
            end
            if (timeout) err <= 1'b1;
            if (store_last && !last_img) begin
                b      <= b + BATCH_W'(1);
                x_base <= x_base + ADDR_WIDTH'(NM);
                y_base <= y_base + ADDR_WIDTH'(MK);
            end
            // Row 0 of each buffer is always the current beat; the buffers rotate underneath.
            unique case (state)
                S_STREAM: begin
                    arr_x <= x_buf[RX-1:0];
                    arr_w <= w_buf[RW-1:0];
                end
                S_WAIT: arr_x <= '0;
                default: begin
                    arr_x <= '0;
                    arr_w <= '0;
                end
            endcase
        end
    end

    // Reads arrive in ascending order, so they shift in from the top; N row rotations per
    // image bring W back to its loaded order for the next image.
    always_ff @(posedge clk) begin
        if (rd_vld && rd_w)  w_buf <= {mem_rdata, w_buf[WW-1:DATA_WIDTH]};
        if (rd_vld && !rd_w) x_buf <= {mem_rdata, x_buf[XW-1:DATA_WIDTH]};
        if (state == S_STREAM) begin
            x_buf <= {x_buf[RX-1:0], x_buf[XW-1:RX]};
            w_buf <= {w_buf[RW-1:0], w_buf[WW-1:RW]};
        end
        if (state == S_WAIT && arr_done) y_reg <= arr_y;
        else if (state == S_STORE)       y_reg <= y_reg >> DATA_WIDTH;
    end
endmodule

// File: tb/tb_conv_gemm_sequencer.sv
// Bench for conv_gemm_sequencer: address-function memory, behavioural accumulating array,
// scoreboard of expected Y writes, table of job configs plus hand-written corner sequences.
module tb_conv_gemm_sequencer;
    localparam int DW = 32, AW = 32, M = 9, N = 9, K = 2, BW = 4, WMAX = 256;
    localparam int NK = N * K, NM = N * M, MK = M * K;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0]     cfg_x_base = '0, cfg_w_base = '0, cfg_y_base = '0;
    logic [BW-1:0]     cfg_batch = '0;
    logic              busy, done, err, mem_wr_en, arr_rst_n, arr_done;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;
    logic [DW*M-1:0]   arr_x;
    logic [DW*K-1:0]   arr_w;
    logic [DW*MK-1:0]  arr_y;

    conv_gemm_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .M(M), .N(N), .K(K),
                          .BATCH_W(BW), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_x_base(cfg_x_base), .cfg_w_base(cfg_w_base), .cfg_y_base(cfg_y_base),
        .cfg_batch(cfg_batch), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arr_rst_n(arr_rst_n), .arr_x(arr_x), .arr_w(arr_w),
        .arr_y(arr_y), .arr_done(arr_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int batch, xpat, wpat; logic [AW-1:0] xb, wb, yb; int exp_rd, exp_wr; } vec_t;

    wr_t sb_q[$];
    int  tests = 0, fails = 0;
    int  rd_cnt, wr_cnt, done_cnt, rise_cyc, done_cyc, cyc = 0;
    logic [AW-1:0] m_xb = '0, m_wb = '0;
    int  m_batch = 0, m_xpat = 0, m_wpat = 0;
    bit  arr_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] xval(int b, int e, int pat);
        if (pat == 0) return 1;
        return DW'((b * 37 + e * 5 + pat * 3) % 17 + 1);
    endfunction

    function automatic logic [DW-1:0] wval(int e, int pat);
        if (pat == 0) return 2;
        return DW'((e * 7 + pat) % 9 + 1);
    endfunction

    // memory contents are a pure function of the address relative to the current job bases
    function automatic logic [DW-1:0] rd_model(logic [AW-1:0] a);
        logic [AW-1:0] ow, ox;
        ow = a - m_wb;
        ox = a - m_xb;
        if (ow < AW'(NK)) return wval(int'(ow), m_wpat);
        if (ox < AW'(m_batch * NM)) return xval(int'(ox) / NM, int'(ox) % NM, m_xpat);
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk) mem_rdata <= rd_model(mem_addr);
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural array: accumulates outer products while out of reset
    logic [DW-1:0] acc [MK];
    int            hi_cnt = 0;
    always @(posedge clk) begin
        if (!arr_rst_n) begin
            for (int e = 0; e < MK; e++) acc[e] <= '0;
            hi_cnt <= 0;
        end else begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < K; j++)
                    acc[i*K+j] <= acc[i*K+j] + arr_x[i*DW +: DW] * arr_w[j*DW +: DW];
            hi_cnt <= hi_cnt + 1;
        end
    end
    assign arr_done = arr_rst_n && arr_en && (hi_cnt >= N + 3);
    always_comb begin
        arr_y = '0;
        for (int e = 0; e < MK; e++) arr_y[e*DW +: DW] = acc[e];
    end

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected write: addr %0h data %0h", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("write addr", mem_addr, e.addr);
                chk("write data", mem_wdata, e.data);
            end
        end else if (busy && mem_addr != '0) begin
            rd_cnt++;
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (arr_rst_n && rise_cyc < 0) rise_cyc = cyc;
    end

    task automatic prep(input vec_t v, input bit expect_out);
        m_xb = v.xb; m_wb = v.wb; m_batch = v.batch; m_xpat = v.xpat; m_wpat = v.wpat;
        if (expect_out)
            for (int b = 0; b < v.batch; b++)
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < K; j++) begin
                        wr_t e;
                        logic [DW-1:0] s;
                        s = '0;
                        for (int c = 0; c < N; c++)
                            s += xval(b, c * M + i, v.xpat) * wval(c * K + j, v.wpat);
                        e.addr = v.yb + AW'(b * MK + i * K + j);
                        e.data = s;
                        sb_q.push_back(e);
                    end
        cfg_x_base = v.xb; cfg_w_base = v.wb; cfg_y_base = v.yb; cfg_batch = BW'(v.batch);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; rise_cyc = -1; done_cyc = -1;
    endtask

    task automatic kick();
        @(negedge clk); #2 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit inject, output int lat);
        bit injected;
        injected = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20000; n++) begin
            @(negedge clk); #2;
            if (n == 1) chk("busy after start", busy, 1);
            start = 1'b0;
            if (inject && !injected && arr_rst_n) begin
                cfg_x_base = 32'h3000; cfg_w_base = 32'h3100; cfg_y_base = 32'h3200;
                cfg_batch = 4'd5; start = 1'b1; injected = 1'b1;
            end
            if (done_cnt > 0) begin lat = n; break; end
        end
        start = 1'b0;
        if (lat == 0) begin
            tests++; fails++;
            $display("FAIL job timeout: no done within 20000 cycles");
        end
        @(negedge clk); #2;
        chk("busy after done", busy, 0);
    endtask

    initial begin
        vec_t vt[5];
        vec_t v;
        int lat, snap;
        bit hit;
        vt[0] = '{1, 0, 0, 32'd64,         32'd16,     32'd1024,       99,  18};
        vt[1] = '{3, 1, 1, 32'd200,        32'd16,     32'd2048,      261,  54};
        vt[2] = '{0, 0, 0, 32'd64,         32'd16,     32'd1024,        0,   0};
        vt[3] = '{1, 2, 3, 32'd64,         32'd32,     32'hFFFF_FFF8,  99,  18};
        vt[4] = '{2, 3, 2, 32'h0001_0000,  32'h8000,   32'h0002_0000, 180,  36};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst wr_en", mem_wr_en, 0);
        chk("rst arr_rst_n", arr_rst_n, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst arr_x/arr_w", 64'((arr_x != '0) || (arr_w != '0)), 0);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            prep(vt[t], 1'b1);
            kick();
            wait_done(1'b0, lat);
            chk($sformatf("vec%0d reads", t), rd_cnt, vt[t].exp_rd);
            chk($sformatf("vec%0d writes", t), wr_cnt, vt[t].exp_wr);
            chk($sformatf("vec%0d done count", t), done_cnt, 1);
            chk($sformatf("vec%0d err", t), err, 0);
            chk($sformatf("vec%0d pending", t), sb_q.size(), 0);
            if (vt[t].batch == 0) chk("batch0 latency", lat, 1);
        end

        // array never completes: timeout on the first image, nothing stored
        arr_en = 1'b0;
        v = '{2, 1, 2, 32'd64, 32'd16, 32'd1024, 0, 0};
        prep(v, 1'b0);
        kick();
        wait_done(1'b0, lat);
        chk("timeout err", err, 1);
        chk("timeout writes", wr_cnt, 0);
        chk("timeout reads", rd_cnt, 99);
        chk("timeout done count", done_cnt, 1);
        chk("timeout cycles", done_cyc - rise_cyc, N + WMAX);
        arr_en = 1'b1;

        // start with different cfg during STREAM is ignored; also clears err from before
        v = '{2, 2, 1, 32'd300, 32'd40, 32'd1500, 0, 0};
        prep(v, 1'b1);
        kick();
        wait_done(1'b1, lat);
        chk("inject writes", wr_cnt, 36);
        chk("inject reads", rd_cnt, 180);
        chk("inject pending", sb_q.size(), 0);
        chk("inject err cleared", err, 0);

        // async reset in the middle of STORE
        v = '{1, 1, 3, 32'd500, 32'd16, 32'd3000, 0, 0};
        prep(v, 1'b1);
        kick();
        hit = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk); #2;
            if (wr_cnt >= 5) begin hit = 1'b1; break; end
        end
        chk("reached store", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst wr_en", mem_wr_en, 0);
        chk("midrst busy", busy, 0);
        chk("midrst arr_rst_n", arr_rst_n, 0);
        chk("midrst mem_addr", mem_addr, 0);
        chk("midrst wdata", mem_wdata, 0);
        chk("midrst arr_x/arr_w", 64'((arr_x != '0) || (arr_w != '0)), 0);
        snap = wr_cnt;
        repeat (3) @(negedge clk);
        chk("midrst no writes", wr_cnt, snap);
        sb_q.delete();
        #2 rst_n = 1'b1;
        prep(v, 1'b1);
        kick();
        wait_done(1'b0, lat);
        chk("post-reset writes", wr_cnt, 18);
        chk("post-reset reads", rd_cnt, 99);
        chk("post-reset pending", sb_q.size(), 0);
        chk("post-reset err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
